// File: rtl/cohort_noc2_packetizer.sv
// ---------------------------------------------------------------------------
// cohort_noc2_packetizer
//
// Turns one translated memory request into a NoC2 packet: three header
// flits (routing/type, address/size, source id) followed by zero, one or
// two data flits. Output flow control is credit based: a flit goes out only
// while the credit counter is nonzero, and each noc_yummy pulse returns one
// credit.
//
// Optional feature: define COHORT_NOC2_PKT_PERF_EN to add the 32-bit
// performance counters pkt_count and stall_count.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_type, req_mshrid, req_address, req_size, req_homeid,
//   req_write_mask, req_data_0, req_data_1   request fields
//   noc_valid/noc_data flit output
//   noc_yummy          one credit returned
//   credit_err         sticky: credit returned while counter was full
//   pkt_count          (perf build) packets completed
//   stall_count        (perf build) cycles blocked on zero credits
// ---------------------------------------------------------------------------
module cohort_noc2_packetizer #(
    parameter int          CREDITS    = 8,
    parameter logic [13:0] SRC_CHIPID = 14'd0,
    parameter logic [7:0]  SRC_X      = 8'd0,
    parameter logic [7:0]  SRC_Y      = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_type,
    input  logic [7:0]  req_mshrid,
    input  logic [39:0] req_address,
    input  logic [2:0]  req_size,
    input  logic [15:0] req_homeid,
    input  logic [15:0] req_write_mask,
    input  logic [63:0] req_data_0,
    input  logic [63:0] req_data_1,
    output logic        noc_valid,
    output logic [63:0] noc_data,
    input  logic        noc_yummy,
    output logic        credit_err
`ifdef COHORT_NOC2_PKT_PERF_EN
    ,
    output logic [31:0] pkt_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_HDR2 = 3'd3,
        S_DAT0 = 3'd4,
        S_DAT1 = 3'd5
    } state_t;

    localparam logic [3:0] CREDITS_MAX = 4'(CREDITS);

    state_t      r_state;
    logic [7:0]  r_type;
    logic [7:0]  r_mshrid;
    logic [39:0] r_addr;
    logic [2:0]  r_size;
    logic [15:0] r_home;
    logic [63:0] r_data0;
    logic [63:0] r_data1;
    logic [1:0]  r_dcnt;
    logic [3:0]  r_credits;
    logic        r_credit_err;

    logic [1:0]  w_dcnt;
    logic        w_send;
    logic        w_last;
    logic [7:0]  w_len;

    // Number of data flits implied by the incoming request.
    assign w_dcnt = (req_write_mask == 16'd0) ? 2'd0 :
                    (req_size <= 3'd3)        ? 2'd1 : 2'd2;

    // A flit leaves in any non-IDLE state as long as a credit is held.
    assign w_send = (r_state != S_IDLE) && (r_credits != 4'd0);

    // The flit going out now closes the packet.
    assign w_last = w_send && (((r_state == S_HDR2) && (r_dcnt == 2'd0)) ||
                               ((r_state == S_DAT0) && (r_dcnt != 2'd2)) ||
                               (r_state == S_DAT1));

    assign w_len      = 8'd2 + {6'd0, r_dcnt};
    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign noc_valid  = w_send;
    assign credit_err = r_credit_err;

    // Flit mux: a pure decode of the registered state and captured fields,
    // so noc_data stays put while the FSM is stalled on credits.
    always_comb begin
        noc_data = 64'd0;
        case (r_state)
            S_HDR0:  noc_data = {14'd0, r_home[7:0], r_home[15:8], 4'd0,
                                 w_len, r_type, r_mshrid, 6'd0};
            S_HDR1:  noc_data = {r_addr, r_size, 21'd0};
            S_HDR2:  noc_data = {SRC_CHIPID, SRC_X, SRC_Y, 34'd0};
            S_DAT0:  noc_data = r_data0;
            S_DAT1:  noc_data = r_data1;
            default: noc_data = 64'd0;
        endcase
    end

    // Packet FSM: captures the request in IDLE, then steps one flit per sent cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_type   <= 8'd0;
            r_mshrid <= 8'd0;
            r_addr   <= 40'd0;
            r_size   <= 3'd0;
            r_home   <= 16'd0;
            r_data0  <= 64'd0;
            r_data1  <= 64'd0;
            r_dcnt   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_type   <= req_type;
                        r_mshrid <= req_mshrid;
                        r_addr   <= req_address;
                        r_size   <= req_size;
                        r_home   <= req_homeid;
                        r_data0  <= req_data_0;
                        r_data1  <= req_data_1;
                        r_dcnt   <= w_dcnt;
                        r_state  <= S_HDR0;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_HDR0: if (w_send) r_state <= S_HDR1; else r_state <= S_HDR0;
                S_HDR1: if (w_send) r_state <= S_HDR2; else r_state <= S_HDR1;
                S_HDR2: begin
                    if (w_send) r_state <= (r_dcnt != 2'd0) ? S_DAT0 : S_IDLE;
                    else        r_state <= S_HDR2;
                end
                S_DAT0: begin
                    if (w_send) r_state <= (r_dcnt == 2'd2) ? S_DAT1 : S_IDLE;
                    else        r_state <= S_DAT0;
                end
                S_DAT1: if (w_send) r_state <= S_IDLE; else r_state <= S_DAT1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Credit counter; a return while already full is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits    <= CREDITS_MAX;
            r_credit_err <= 1'b0;
        end else if (w_send && !noc_yummy) begin
            r_credits    <= r_credits - 4'd1;
        end else if (!w_send && noc_yummy) begin
            if (r_credits == CREDITS_MAX) r_credit_err <= 1'b1;
            else                          r_credits    <= r_credits + 4'd1;
        end else begin
            r_credits    <= r_credits;
        end
    end

`ifdef COHORT_NOC2_PKT_PERF_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_stall_count;

    // Performance counters: completed packets and credit-starved cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count   <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_last) r_pkt_count <= r_pkt_count + 32'd1;
            else        r_pkt_count <= r_pkt_count;
            if ((r_state != S_IDLE) && (r_credits == 4'd0))
                r_stall_count <= r_stall_count + 32'd1;
            else
                r_stall_count <= r_stall_count;
        end
    end

    assign pkt_count   = r_pkt_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: doc/cohort_noc2_packetizer.md
COHORT_NOC2_PACKETIZER -- requirements
Module: cohort_noc2_packetizer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  - CREDITS, 8, NoC2 output buffer credits (1..15).
  - SRC_CHIPID, 14'd0, source chip id.
  - SRC_X, 8'd0, source tile x.
  - SRC_Y, 8'd0, source tile y.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  asynchronous active-high reset.
  - req_valid  in  1  translated mem request valid.
  - req_ready  out  1  request accepted this cycle when high with req_valid.
  - req_type  in  8  NoC message type.
  - req_mshrid  in  8  MSHR id.
  - req_address  in  40  physical address.
  - req_size  in  3  log2 access bytes.
  - req_homeid  in  16  [7:0] dest x, [15:8] dest y.
  - req_write_mask  in  16  byte mask; 0 means no data.
  - req_data_0  in  64  first data word.
  - req_data_1  in  64  second data word.
  - noc_valid  out  1  flit valid.
  - noc_data  out  64  flit.
  - noc_yummy  in  1  one credit returned.
  - credit_err  out  1  sticky credit overflow flag.

Function
REQ-003 FSM states SHALL be IDLE, HDR0, HDR1, HDR2, DAT0, DAT1; req_ready SHALL equal (state==IDLE); acceptance SHALL register all req_* fields and move to HDR0.
REQ-004 Data flit count D SHALL be: 0 if write_mask==0; 1 if mask!=0 and size<=3; 2 otherwise.
REQ-005 Flit formats SHALL be:
  - HDR0: [63:50]=0 (dest chipid), [49:42]=dest x, [41:34]=dest y, [33:30]=0, [29:22]=2+D, [21:14]=req_type, [13:6]=mshrid, [5:0]=0.
  - HDR1: [63:24]=address, [23:21]=size, [20:0]=0.
  - HDR2: [63:50]=SRC_CHIPID, [49:42]=SRC_X, [41:34]=SRC_Y, [33:0]=0.
  - DAT0: req_data_0.
  - DAT1: req_data_1.
REQ-006 noc_valid SHALL be high in states HDR0..DAT1 only when the credit counter is nonzero; a flit SHALL be sent in exactly that cycle, after which the FSM advances: HDR2 goes to DAT0 if D>0, else to IDLE; DAT0 goes to DAT1 if D==2, else to IDLE; DAT1 goes to IDLE.
REQ-007 With zero credits, the FSM SHALL hold its state and noc_data unchanged, with noc_valid low.
REQ-008 Latency SHALL be: request accepted at cycle N gives HDR0 at N+1 with credits available; back-to-back packets SHALL have one idle (IDLE/accept) cycle between the last flit and the next HDR0.
REQ-009 Credit counter (4 bits) SHALL:
  - decrement on a sent flit;
  - increment on noc_yummy;
  - hold on simultaneous send and yummy.
REQ-010 A yummy with counter==CREDITS and no send SHALL leave the counter at CREDITS and set credit_err until reset.
REQ-011 req_* inputs SHALL be ignored outside IDLE; registered fields SHALL not change mid-packet.

Reset
REQ-012 rst SHALL asynchronously force all of the following: state IDLE, credits=CREDITS, noc_valid=0, noc_data=0, credit_err=0, req_ready=0 while rst is high, and req_ready=1 the first cycle after release.
REQ-013 Reset mid-packet SHALL abandon the packet; no further flits of it SHALL be emitted.

Configuration
REQ-014 With COHORT_NOC2_PKT_PERF_EN defined, ports pkt_count (out 32) and stall_count (out 32) SHALL exist, both reset to 0:
  - pkt_count increments on each last flit sent.
  - stall_count increments each cycle in HDR0..DAT1 with zero credits.
  - Both wrap at 2^32.
REQ-015 Without COHORT_NOC2_PKT_PERF_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-016 Load: mask=0, type=8'h31, mshrid=8'h80, addr=40'h12_3456_7880, homeid=16'h0201, credits=8 -> 3 flits on consecutive cycles, HDR0 [29:22]=2, x=1, y=2, mshrid=0x80; credits end at 5.
REQ-017 Store: size=3, mask=16'h00FF -> 4 flits, the last being data_0; size=4, mask=16'hFFFF -> 5 flits ending with data_0 then data_1; payload length 3 and 4 respectively.
REQ-018 CREDITS=2, no yummy, load request -> 2 flits sent, then noc_valid low with HDR2 held; a single yummy -> HDR2 sent next cycle, then IDLE.
REQ-019 Simultaneous send and yummy every cycle for a 5-flit packet -> credits stay 8; an extra yummy at 8 -> credit_err=1, counter stays 8.
REQ-020 rst asserted during DAT0 -> noc_valid=0 immediately; after release req_ready=1, credits=8, and no stale DAT flit is emitted.
REQ-021 Under COHORT_NOC2_PKT_PERF_EN, with 3 packets and 4 zero-credit cycles -> pkt_count=3, stall_count=4.
